// File: rtl/commit_trace_packer.sv
// Commit-stage trace source: packs up to two retirements plus one exception per cycle into
// fixed-format records, buffers them, and serializes them onto a 64-bit valid/ready stream.
module commit_trace_packer #(
    parameter int unsigned DEPTH = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         enable_i,
    input  logic [1:0]   commit_ack_i,
    input  logic [127:0] commit_pc_i,
    input  logic [63:0]  commit_instr_i,
    input  logic [1:0]   we_i,
    input  logic [9:0]   waddr_i,
    input  logic [127:0] wdata_i,
    input  logic [1:0]   priv_lvl_i,
    input  logic         debug_mode_i,
    input  logic         ex_valid_i,
    input  logic [63:0]  ex_cause_i,
    input  logic [63:0]  ex_tval_i,
    output logic         trace_valid_o,
    output logic [63:0]  trace_data_o,
    output logic         trace_last_o,
    input  logic         trace_ready_i,
    output logic [15:0]  drop_cnt_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef struct packed {
        logic        three;
        logic [63:0] hdr;
        logic [63:0] pc;
        logic [63:0] pay;
    } rec_t;

    typedef enum logic [1:0] {StIdle, StHdr, StPc, StPay} state_e;

    state_e         state_q, state_d;
    logic [PW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [15:0]    seq_q, seq_d;
    logic [15:0]    drop_q, drop_d;
    logic           lost_q, lost_d;

    rec_t           mem [DEPTH];
    rec_t           head;
    rec_t           cand_rec [3];
    rec_t           wr_rec [3];
    logic [AW-1:0]  widx [3];
    logic [2:0]     wr_en;
    logic [2:0]     cand;
    logic [1:0]     pos [3];
    logic [1:0]     k;
    logic [PW-1:0]  occ, free;
    logic           admit;
    logic           empty;
    logic           more_after_pop;
    logic           pop;
    logic [16:0]    drop_sum;
    logic           bkpt;

    // Breakpoints taken while already in debug mode are the debugger's own traps, not trace events.
    assign bkpt    = debug_mode_i && (ex_cause_i == 64'd3);
    assign cand[0] = enable_i & commit_ack_i[0];
    assign cand[1] = enable_i & commit_ack_i[1];
    assign cand[2] = enable_i & ex_valid_i & ~bkpt;

    // Slot position of each candidate among this cycle's candidates; also its seq offset.
    assign pos[0] = 2'd0;
    assign pos[1] = 2'(cand[0]);
    assign pos[2] = 2'(cand[0]) + 2'(cand[1]);
    assign k      = pos[2] + 2'(cand[2]);

    assign occ   = wptr_q - rptr_q;
    assign free  = PW'(DEPTH) - occ;
    assign admit = (PW'(k) <= free);
    assign empty = (wptr_q == rptr_q);

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            cand_rec[i].three = we_i[i];
            cand_rec[i].hdr   = {2'b01, lost_q && (pos[i] == 2'd0), 1'(i), priv_lvl_i,
                                 debug_mode_i, we_i[i], waddr_i[5*i +: 5], 3'b000,
                                 seq_q + 16'(pos[i]), commit_instr_i[32*i +: 32]};
            cand_rec[i].pc    = commit_pc_i[64*i +: 64];
            cand_rec[i].pay   = wdata_i[64*i +: 64];
        end
        cand_rec[2].three = 1'b1;
        cand_rec[2].hdr   = {2'b10, lost_q && (pos[2] == 2'd0), 1'b0, priv_lvl_i, debug_mode_i,
                             9'd0, seq_q + 16'(pos[2]), ex_cause_i[31:0]};
        cand_rec[2].pc    = commit_pc_i[63:0];
        cand_rec[2].pay   = ex_tval_i;
    end

    // Compact present candidates into consecutive write slots, preserving priority order.
    always_comb begin
        for (int j = 0; j < 3; j++) begin
            wr_rec[j] = '0;
        end
        for (int j = 0; j < 3; j++) begin
            if (cand[j]) begin
                wr_rec[pos[j]] = cand_rec[j];
            end
        end
        for (int j = 0; j < 3; j++) begin
            widx[j]  = wptr_q[AW-1:0] + AW'(j);
            wr_en[j] = admit && (2'(j) < k);
        end
    end

    always_ff @(posedge clk_i) begin
        for (int j = 0; j < 3; j++) begin
            if (wr_en[j]) begin
                mem[widx[j]] <= wr_rec[j];
            end
        end
    end

    assign head = mem[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d   = wptr_q + (admit ? PW'(k) : PW'(0));
        rptr_d   = rptr_q + PW'(pop);
        seq_d    = seq_q + 16'(k);
        drop_sum = {1'b0, drop_q} + 17'(k);
        drop_d   = drop_q;
        lost_d   = lost_q;
        if (!admit) begin
            drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            lost_d = 1'b1;
        end else if (k != 2'd0) begin
            lost_d = 1'b0;
        end
    end

    // Decided without pop so the FSM does not depend on its own pop output.
    assign more_after_pop = (wptr_d != (rptr_q + PW'(1)));

    always_comb begin
        state_d       = state_q;
        pop           = 1'b0;
        trace_valid_o = 1'b0;
        trace_data_o  = 64'd0;
        trace_last_o  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    state_d = StHdr;
                end
            end
            StHdr: begin
                trace_valid_o = 1'b1;
                trace_data_o  = head.hdr;
                if (trace_ready_i) begin
                    state_d = StPc;
                end
            end
            StPc: begin
                trace_valid_o = 1'b1;
                trace_data_o  = head.pc;
                trace_last_o  = ~head.three;
                if (trace_ready_i) begin
                    if (head.three) begin
                        state_d = StPay;
                    end else begin
                        pop     = 1'b1;
                        state_d = more_after_pop ? StHdr : StIdle;
                    end
                end
            end
            StPay: begin
                trace_valid_o = 1'b1;
                trace_data_o  = head.pay;
                trace_last_o  = 1'b1;
                if (trace_ready_i) begin
                    pop     = 1'b1;
                    state_d = more_after_pop ? StHdr : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            wptr_q  <= '0;
            rptr_q  <= '0;
            seq_q   <= 16'd0;
            drop_q  <= 16'd0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            seq_q   <= seq_d;
            drop_q  <= drop_d;
            lost_q  <= lost_d;
        end
    end

    assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_commit_trace_packer.sv
// Scoreboard bench for commit_trace_packer: stimulus pushes expected beats, a monitor pops them.
module tb_commit_trace_packer;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         enable_i;
    logic [1:0]   commit_ack_i;
    logic [127:0] commit_pc_i;
    logic [63:0]  commit_instr_i;
    logic [1:0]   we_i;
    logic [9:0]   waddr_i;
    logic [127:0] wdata_i;
    logic [1:0]   priv_lvl_i;
    logic         debug_mode_i;
    logic         ex_valid_i;
    logic [63:0]  ex_cause_i;
    logic [63:0]  ex_tval_i;
    logic         trace_valid_o;
    logic [63:0]  trace_data_o;
    logic         trace_last_o;
    logic         trace_ready_i;
    logic [15:0]  drop_cnt_o;

    int           vectors = 0;
    int           miscompares = 0;
    logic [64:0]  exp_q [$];
    logic [15:0]  exp_seq = 16'd0;
    logic         mon_en = 1'b1;

    always #5 clk_i = ~clk_i;

    commit_trace_packer #(.DEPTH(8)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .enable_i       (enable_i),
        .commit_ack_i   (commit_ack_i),
        .commit_pc_i    (commit_pc_i),
        .commit_instr_i (commit_instr_i),
        .we_i           (we_i),
        .waddr_i        (waddr_i),
        .wdata_i        (wdata_i),
        .priv_lvl_i     (priv_lvl_i),
        .debug_mode_i   (debug_mode_i),
        .ex_valid_i     (ex_valid_i),
        .ex_cause_i     (ex_cause_i),
        .ex_tval_i      (ex_tval_i),
        .trace_valid_o  (trace_valid_o),
        .trace_data_o   (trace_data_o),
        .trace_last_o   (trace_last_o),
        .trace_ready_i  (trace_ready_i),
        .drop_cnt_o     (drop_cnt_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] hdr_c(input logic lost, input logic port,
                                          input logic [1:0] priv, input logic dbg,
                                          input logic we, input logic [4:0] wa,
                                          input logic [15:0] seq, input logic [31:0] instr);
        return {2'b01, lost, port, priv, dbg, we, wa, 3'b000, seq, instr};
    endfunction

    // Monitor: checks every handshake against the queue and stability of stalled beats.
    initial begin
        logic        prev_stall;
        logic [63:0] prev_data;
        logic        prev_last;
        logic [64:0] e;
        prev_stall = 1'b0;
        prev_data  = 64'd0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni || !mon_en) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", 64'(trace_valid_o), 64'd1);
                    chk("stall_data", trace_data_o, prev_data);
                    chk("stall_last", 64'(trace_last_o), 64'(prev_last));
                end
                if (trace_valid_o && trace_ready_i) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_beat: got %h, expected no beat", trace_data_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", trace_data_o, e[63:0]);
                        chk("beat_last", 64'(trace_last_o), 64'(e[64]));
                    end
                end
                prev_stall = trace_valid_o && !trace_ready_i;
                prev_data  = trace_data_o;
                prev_last  = trace_last_o;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        enable_i       = 1'b1;
        commit_ack_i   = 2'b00;
        commit_pc_i    = '0;
        commit_instr_i = '0;
        we_i           = 2'b00;
        waddr_i        = '0;
        wdata_i        = '0;
        priv_lvl_i     = 2'b00;
        debug_mode_i   = 1'b0;
        ex_valid_i     = 1'b0;
        ex_cause_i     = '0;
        ex_tval_i      = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        trace_ready_i = 1'b0;
        rst_ni = 1'b0;
        repeat (2) tick();
        exp_q.delete();
        exp_seq = 16'd0;
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic send_commit(input logic [63:0] pc, input logic [31:0] instr,
                               input logic lost, input bit expect_it);
        commit_ack_i   = 2'b01;
        commit_pc_i    = {64'd0, pc};
        commit_instr_i = {32'd0, instr};
        if (expect_it) begin
            exp_q.push_back({1'b0, hdr_c(lost, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0, exp_seq, instr)});
            exp_q.push_back({1'b1, pc});
        end
        exp_seq++;
        tick();
        idle_inputs();
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) begin
            send_commit(64'h100 + 64'(8 * i), 32'h13 | (32'(i) << 7), 1'b0, 1'b1);
        end
    endtask

    task automatic drop_cycles(input int n, input logic [1:0] ack, input logic ex);
        commit_ack_i = ack;
        ex_valid_i   = ex;
        repeat (n) tick();
        exp_seq = exp_seq + 16'(n * (int'(ack[0]) + int'(ack[1]) + int'(ex)));
        idle_inputs();
    endtask

    task automatic drain(input int budget);
        bit done;
        done = 1'b0;
        trace_ready_i = 1'b1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (exp_q.size() == 0 && !trace_valid_o) begin
                done = 1'b1;
                break;
            end
        end
        chk("drain_done", 64'(done), 64'd1);
    endtask

    initial begin
        idle_inputs();
        trace_ready_i = 1'b0;
        rst_ni = 1'b0;
        repeat (3) tick();
        chk("rst_valid", 64'(trace_valid_o), 64'd0);
        chk("rst_data", trace_data_o, 64'd0);
        chk("rst_last", 64'(trace_last_o), 64'd0);
        chk("rst_drop", 64'(drop_cnt_o), 64'd0);
        rst_ni = 1'b1;
        tick();

        // Single commit, and one-cycle latency into an empty FIFO.
        trace_ready_i  = 1'b1;
        commit_ack_i   = 2'b01;
        commit_pc_i    = {64'd0, 64'h8000_0000};
        commit_instr_i = {32'd0, 32'h0000_0013};
        exp_q.push_back({1'b0, 64'h4000_0000_0000_0013});
        exp_q.push_back({1'b1, 64'h0000_0000_8000_0000});
        tick();
        idle_inputs();
        chk("lat_idle", 64'(trace_valid_o), 64'd0);
        tick();
        chk("lat_valid", 64'(trace_valid_o), 64'd1);
        chk("lat_hdr", trace_data_o, 64'h4000_0000_0000_0013);
        drain(20);

        // Dual commit plus exception in one cycle, stalled sink.
        apply_reset();
        commit_ack_i   = 2'b11;
        commit_pc_i    = {64'h1004, 64'h1000};
        commit_instr_i = {32'h00a0_0113, 32'h0050_0093};
        we_i           = 2'b11;
        waddr_i        = {5'd2, 5'd1};
        wdata_i        = {64'd10, 64'd5};
        priv_lvl_i     = 2'b11;
        ex_valid_i     = 1'b1;
        ex_cause_i     = 64'd2;
        ex_tval_i      = 64'hDEAD;
        exp_q.push_back({1'b0, 64'h4D08_0000_0050_0093});
        exp_q.push_back({1'b0, 64'h1000});
        exp_q.push_back({1'b1, 64'd5});
        exp_q.push_back({1'b0, 64'h5D10_0001_00A0_0113});
        exp_q.push_back({1'b0, 64'h1004});
        exp_q.push_back({1'b1, 64'd10});
        exp_q.push_back({1'b0, 64'h8C00_0002_0000_0002});
        exp_q.push_back({1'b0, 64'h1000});
        exp_q.push_back({1'b1, 64'hDEAD});
        tick();
        idle_inputs();
        exp_seq = 16'd3;
        repeat (5) tick();
        drain(40);

        // Debug breakpoint filter and enable gating leave seq untouched.
        ex_valid_i   = 1'b1;
        ex_cause_i   = 64'd3;
        debug_mode_i = 1'b1;
        tick();
        idle_inputs();
        repeat (3) begin
            tick();
            chk("bkpt_no_record", 64'(trace_valid_o), 64'd0);
        end
        enable_i     = 1'b0;
        commit_ack_i = 2'b01;
        tick();
        idle_inputs();
        repeat (3) tick();
        chk("enable_off_no_record", 64'(trace_valid_o), 64'd0);
        ex_valid_i  = 1'b1;
        ex_cause_i  = 64'd3;
        commit_pc_i = {64'd0, 64'h4000};
        ex_tval_i   = 64'hBEEF;
        exp_q.push_back({1'b0, 64'h8000_0003_0000_0003});
        exp_q.push_back({1'b0, 64'h4000});
        exp_q.push_back({1'b1, 64'hBEEF});
        tick();
        idle_inputs();
        exp_seq = 16'd4;
        drain(20);
        chk("filter_drop", 64'(drop_cnt_o), 64'd0);

        // Overflow: full FIFO drops a two-commit cycle; lost flag marks the next record only.
        apply_reset();
        fill(8);
        commit_ack_i = 2'b11;
        tick();
        idle_inputs();
        exp_seq = exp_seq + 16'd2;
        chk("ovf_drop", 64'(drop_cnt_o), 64'd2);
        drain(60);
        send_commit(64'h900, 32'h93, 1'b1, 1'b1);
        send_commit(64'h904, 32'h113, 1'b0, 1'b1);
        drain(20);

        // Seq wrap via mass drops, then drop counter saturation.
        trace_ready_i = 1'b0;
        fill(8);
        drop_cycles(21838, 2'b11, 1'b1);
        drop_cycles(1, 2'b01, 1'b0);
        chk("wrap_drop", 64'(drop_cnt_o), 64'hFFED);
        drain(60);
        send_commit(64'hA00, 32'h13, 1'b1, 1'b1);
        send_commit(64'hA04, 32'h13, 1'b0, 1'b1);
        drain(20);
        trace_ready_i = 1'b0;
        fill(8);
        drop_cycles(5, 2'b11, 1'b1);
        drop_cycles(1, 2'b11, 1'b0);
        chk("sat_fffe", 64'(drop_cnt_o), 64'hFFFE);
        drop_cycles(1, 2'b11, 1'b1);
        chk("sat_ffff", 64'(drop_cnt_o), 64'hFFFF);
        drop_cycles(1, 2'b11, 1'b1);
        chk("sat_hold", 64'(drop_cnt_o), 64'hFFFF);
        drain(60);

        // Reset asserted during the PC beat discards the record.
        mon_en = 1'b0;
        trace_ready_i = 1'b1;
        send_commit(64'h2222, 32'h33, 1'b0, 1'b0);
        tick();
        tick();
        chk("mid_pc_beat", trace_data_o, 64'h2222);
        chk("mid_pc_last", 64'(trace_last_o), 64'd1);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(trace_valid_o), 64'd0);
        chk("mid_rst_data", trace_data_o, 64'd0);
        chk("mid_rst_last", 64'(trace_last_o), 64'd0);
        chk("mid_rst_drop", 64'(drop_cnt_o), 64'd0);
        tick();
        tick();
        exp_q.delete();
        exp_seq = 16'd0;
        rst_ni = 1'b1;
        mon_en = 1'b1;
        repeat (4) begin
            tick();
            chk("no_residual", 64'(trace_valid_o), 64'd0);
        end
        send_commit(64'h3000, 32'h13, 1'b0, 1'b1);
        drain(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/commit_trace_packer.md
# commit_trace_packer

Synthesizable commit-stage trace source that sits alongside the commit stage, on the same signals the simulation instruction tracer samples. It captures up to two retiring instructions plus one exception per cycle as fixed-format trace records. Records are buffered in a small FIFO and serialized onto a 64-bit valid/ready stream, which feeds an off-core trace sink or DMA. Loss is never silent: overflow is counted, and every record carries a sequence number.

## Interface
- DEPTH, 8, FIFO depth in records; power of 2, minimum 4.
- clk_i  in  1  core clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- enable_i  in  1  record generation enable; the drain side is unaffected.
- commit_ack_i  in  2  per-port retire strobe.
- commit_pc_i  in  2x64  PC of each retiring instruction.
- commit_instr_i  in  2x32  raw instruction word of each port.
- we_i  in  2  register write-back valid (GPR or FPR) per port.
- waddr_i  in  2x5  destination register per port.
- wdata_i  in  2x64  write-back data per port.
- priv_lvl_i  in  2  current privilege level.
- debug_mode_i  in  1  core is in debug mode.
- ex_valid_i, ex_cause_i[63:0], ex_tval_i[63:0]  in  exception taken this cycle.
- trace_valid_o  out  1  beat valid.
- trace_data_o  out  64  beat payload.
- trace_last_o  out  1  final beat of a record.
- trace_ready_i  in  1  sink accepts the beat.
- drop_cnt_o  out  16  count of dropped records; saturates at 16'hFFFF.

## Operation
- Record generation happens in a single cycle, gated by enable_i.
  - Candidates, in fixed order: port 0 commit, port 1 commit, exception.
  - A commit candidate exists when commit_ack_i[i] is high.
  - An exception candidate exists when ex_valid_i is high, except when debug_mode_i=1 and ex_cause_i=3 (breakpoint); that case produces no record.
- Sequence counter seq[15:0] advances by 1 per candidate, including dropped ones. It wraps FFFF→0000. Each record's header carries the seq value assigned to that record.
- FIFO admission is all-or-nothing per cycle.
  - Let k be the number of candidates this cycle (0–3) and free = DEPTH − occupancy, using the registered occupancy. A pop in the same cycle is not credited.
  - If k ≤ free, all k records are written in order.
  - Otherwise none are written, drop_cnt_o increases by k (saturating), and a sticky lost flag is set.
  - The lost flag is copied into bit 61 of the next admitted record's header, then cleared.
- Commit record: 2 beats if we_i=0, 3 beats if we_i=1.
  - Beat 0 header: [63:62]=2'b01, [61]=lost, [60]=port index, [59:58]=priv, [57]=debug, [56]=we, [55:51]=waddr, [50:48]=0, [47:32]=seq, [31:0]=instr.
  - Beat 1: pc.
  - Beat 2 (only if we_i=1): wdata.
- Exception record: always 3 beats.
  - Beat 0 header: [63:62]=2'b10, [61]=lost, [60]=0, [59:58]=priv, [57]=debug, [56:48]=0, [47:32]=seq, [31:0]=cause[31:0].
  - Beat 1: commit_pc_i[0].
  - Beat 2: tval.
- Serializer FSM states: IDLE, HDR, PC, PAY.
  - IDLE → HDR when the FIFO is non-empty.
  - HDR → PC on handshake.
  - PC → PAY on handshake if the record has 3 beats. Otherwise PC is the last beat: pop the record, then go to HDR if the FIFO is still non-empty after the pop, else IDLE.
  - PAY → pop the record, then HDR if the FIFO is still non-empty after the pop, else IDLE.
- trace_last_o is high on the final beat only.
- While trace_valid_o=1 and trace_ready_i=0, trace_data_o and trace_last_o hold stable. trace_valid_o is never withdrawn without a handshake.
- Deasserting enable_i mid-stream: records already in the FIFO still drain completely. seq and the lost flag hold their values.

## Timing
- Reset values: trace_valid_o=0, trace_data_o=0, trace_last_o=0, drop_cnt_o=0, seq=0, lost=0, FIFO empty, FSM=IDLE. Reset asserted mid-record discards the record with no partial completion.
- Latency: candidates sampled at edge N appear as the first header at trace_valid_o after edge N+1. That is, 1 cycle into the empty FIFO.
- Throughput: 1 beat per cycle. Consecutive records stream back-to-back with no idle beat while trace_ready_i=1.
- Write and pop in the same cycle are both performed. Occupancy updates by writes − pops.
- Pointers are log2(DEPTH) bits plus 1 wrap bit. full/empty are decided from the wrap bit.

## Test plan
- Single commit: port 0, pc=0x8000_0000, instr=0x0000_0013, we=0, ready=1 → 2 beats.
  - Beat 0 = 0x4000_0000_0000_0013 (seq=0), beat 1 = 0x8000_0000. last set on beat 1.
- Dual commit plus exception in one cycle, cause=2, tval=0xDEAD, both ports we=1, ready held 0 for 5 cycles then 1 → 3 records in order: port0, port1, exception.
  - seq = 0, 1, 2; 3+3+3 = 9 beats.
  - Data held stable during the stall.
- Debug breakpoint filter: ex_valid=1, cause=3, debug_mode=1 → no record, seq unchanged. Same stimulus with debug_mode=0 → exception record.
- Overflow: ready=0, fill DEPTH=8 records, then one cycle with 2 commits → both dropped, drop_cnt_o=2, seq advances by 2.
  - After draining, the next admitted header has bit 61=1 and its seq shows a gap of 2. The header after that has bit 61=0.
- Wrap and saturation: preload seq=0xFFFF → next record seq=0xFFFF, following 0x0000. Force drop_cnt_o=0xFFFE and drop 3 → 0xFFFF.
- Reset mid-record: assert rst_ni low during the PC beat → all outputs 0 immediately. After release, no residual beats; the first new record has seq=0.
